// File: rtl/hazard_control.sv
// Pipeline hazard unit: load-use stall, branch flush and multi-cycle mult/div hold,
// plus a saturating counter of PC-stall cycles.
module hazard_control #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic [4:0]  ID_EX_Rt,
    input  logic        ID_EX_MemRead,
    input  logic        EX_Branch_Taken,
    input  logic        EX_MD_Start,
    input  logic        EX_MD_Div,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        EX_Hold,
    output logic        MD_Busy,
    output logic        MD_Done,
    output logic [15:0] Stall_Count
);

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       load_use;

    assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Outputs are gated by rst_n so they sit at their idle values during reset
    // whatever the other inputs do.
    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        EX_Hold     = 1'b0;
        MD_Done     = 1'b0;
        state_next  = state;
        cnt_next    = cnt;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (EX_Branch_Taken) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (EX_MD_Start) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        EX_Hold     = 1'b1;
                        state_next  = MD_BUSY;
                        cnt_next    = EX_MD_Div ? DIV_LOAD : MULT_LOAD;
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt != 8'd0) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        EX_Hold     = 1'b1;
                        cnt_next    = cnt - 8'd1;
                    end else begin
                        // Result cycle: normal hazard rules apply, but a new start is ignored.
                        MD_Done    = 1'b1;
                        state_next = RUN;
                        if (EX_Branch_Taken) begin
                            IF_ID_Flush = 1'b1;
                            ID_EX_Flush = 1'b1;
                        end else if (load_use) begin
                            PC_Write    = 1'b0;
                            IF_ID_Write = 1'b0;
                            ID_EX_Flush = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    assign MD_Busy = (state == MD_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Stall_Count <= '0;
        end else if (!PC_Write && (Stall_Count != 16'hFFFF)) begin
            Stall_Count <= Stall_Count + 16'd1;
        end
    end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 Parameter MULT_CYCLES, default 4: EX stall length for multiply; legal range 2..255.
REQ-002 Parameter DIV_CYCLES, default 32: EX stall length for divide; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 IF_ID_Rs  input  5  source register Rs of the instruction in ID.
REQ-006 IF_ID_Rt  input  5  source register Rt of the instruction in ID.
REQ-007 ID_EX_Rt  input  5  destination register of the load in EX.
REQ-008 ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-009 EX_Branch_Taken  input  1  branch/jump resolved taken in EX.
REQ-010 EX_MD_Start  input  1  instruction in EX is mult/div.
REQ-011 EX_MD_Div  input  1  qualifies EX_MD_Start: 1 = divide, 0 = multiply.
REQ-012 PC_Write  output  1  PC update enable.
REQ-013 IF_ID_Write  output  1  IF/ID register load enable.
REQ-014 IF_ID_Flush  output  1  IF/ID register clears to NOP.
REQ-015 ID_EX_Flush  output  1  ID/EX register loads bubble (control zeroed).
REQ-016 EX_Hold  output  1  ID/EX, EX/MEM and the mult/div unit hold state; EX/MEM injects a bubble downstream.
REQ-017 MD_Busy  output  1  high in state MD_BUSY.
REQ-018 MD_Done  output  1  one-cycle pulse: the mult/div result is valid this cycle.
REQ-019 Stall_Count  output  16  count of cycles with PC_Write=0.

Function
REQ-020 Two states: RUN and MD_BUSY; 8-bit down-counter cnt.
REQ-021 Default outputs: PC_Write=1, IF_ID_Write=1, all flushes, EX_Hold and MD_Done = 0.
REQ-022 Load-use hazard = ID_EX_MemRead & ID_EX_Rt!=0 & (ID_EX_Rt==IF_ID_Rs | ID_EX_Rt==IF_ID_Rt).
REQ-023 Evaluation priority in RUN: EX_Branch_Taken, then EX_MD_Start, then load-use.
REQ-024 Branch: IF_ID_Flush=1 and ID_EX_Flush=1, same cycle; PC_Write=1; overrides a coincident load-use hazard.
REQ-025 Load-use: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly one cycle; no state change.
REQ-026 MD start (RUN, no branch): PC_Write=0, IF_ID_Write=0, EX_Hold=1; next state MD_BUSY with cnt = N-1, where N = DIV_CYCLES if EX_MD_Div else MULT_CYCLES.
REQ-027 MD_BUSY, cnt!=0: PC_Write=0, IF_ID_Write=0, EX_Hold=1, cnt decrements; all inputs ignored.
REQ-028 MD_BUSY, cnt==0: MD_Done=1, EX_Hold=0; branch/load-use evaluated as in RUN, EX_MD_Start ignored; next state RUN.
REQ-029 EX_Hold is therefore high for exactly N consecutive cycles; MD_Done fires on cycle N+1 counted from the start cycle.
REQ-030 MD_Busy is registered: MD_Busy = (state==MD_BUSY).
REQ-031 Stall_Count increments on each posedge where PC_Write=0; saturates at 16'hFFFF with no wrap.

Reset
REQ-032 While rst_n=0: state=RUN, cnt=0, Stall_Count=0, all outputs at REQ-021 defaults, MD_Busy=0, regardless of the other inputs.
REQ-033 Reset asserted in MD_BUSY aborts the operation immediately; no MD_Done is generated.
REQ-034 After rst_n deasserts, the first posedge evaluates per the RUN rules.

Verification
REQ-035 Load-use: MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 for one cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for 1 cycle; Stall_Count=1.
REQ-036 ID_EX_Rt=0 with MemRead=1, IF_ID_Rt=0 -> no stall asserted.
REQ-037 Branch plus load-use in the same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; Stall_Count unchanged.
REQ-038 Multiply, default parameters -> EX_Hold high for 4 cycles, MD_Done on cycle 5, Stall_Count=4. Divide -> EX_Hold high for 32 cycles, MD_Done on cycle 33.
REQ-039 rst_n pulsed low at divide cycle 10 -> MD_Busy=0, EX_Hold=0 asynchronously; MD_Done never asserted; Stall_Count=0.
REQ-040 Force 70000 stall cycles -> Stall_Count holds at 16'hFFFF.
